// File: rtl/apb_spi_reg_bank.sv
// APB slave register bank in front of the SPI core: decoded TX/RX/CTRL/STATUS map,
// programmable wait states, PSLVERR, TX valid/ready handshake and an RX holding buffer.
module apb_spi_reg_bank #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 4,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic [DATA_W-1:0] ctrl
);

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    state_t            state_r, state_nxt_s;
    logic [3:0]        wcnt_r;
    logic [ADDR_W-1:0] addr_r;
    logic              write_r;
    logic [DATA_W-1:0] wdata_r;
    logic [DATA_W-1:0] rxbuf_r;
    logic              rx_full_r;
    logic              rx_overrun_r;

    logic              pready_s, err_s, done_s, mapped_s;
    logic [1:0]        idx_s;
    logic [DATA_W-1:0] rdata_s, status_s;
    logic              rx_read_s, new_ovr_s, ovr_clr_s;

    assign idx_s    = addr_r[1:0];
    assign mapped_s = ((addr_r >> 2'd2) == {ADDR_W{1'b0}});
    assign pready_s = (state_r == ACCESS) && (wcnt_r == 4'd0) && PSEL && PENABLE;
    assign done_s   = pready_s & ~err_s;

    assign rx_read_s = done_s & ~write_r & (idx_s == 2'd1);
    // A byte arriving on the very edge the buffer is read is not an overrun.
    assign new_ovr_s = rx_valid & rx_full_r & ~rx_read_s;
    assign ovr_clr_s = done_s & write_r & (idx_s == 2'd3) & wdata_r[2];

    // FSM state, wait counter and setup-phase capture of the transfer.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_r <= IDLE;
            wcnt_r  <= 4'd0;
            addr_r  <= {ADDR_W{1'b0}};
            write_r <= 1'b0;
            wdata_r <= {DATA_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if ((state_r == IDLE) && PSEL && !PENABLE) begin
                addr_r  <= PADDR;
                write_r <= PWRITE;
                wdata_r <= PWDATA;
                wcnt_r  <= WAIT_LD;
            end else if (wcnt_r != 4'd0) begin
                wcnt_r <= wcnt_r - 4'd1;
            end
        end
    end

    // Next-state logic; dropping PSEL mid-access abandons the transfer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    state_nxt_s = (PSEL && !PENABLE) ? ACCESS : IDLE;
            ACCESS:  state_nxt_s = (!PSEL || pready_s) ? IDLE : ACCESS;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Address decode: error classification and read-data mux.
    always_comb begin
        err_s    = 1'b0;
        rdata_s  = {DATA_W{1'b0}};
        status_s = {DATA_W{1'b0}};
        status_s[2:0] = {rx_overrun_r, rx_full_r, tx_valid};
        if (!mapped_s) begin
            err_s = 1'b1;
        end else begin
            case (idx_s)
                2'd0:    err_s = write_r & tx_valid;
                2'd1:    begin err_s = write_r; rdata_s = rxbuf_r; end
                2'd2:    rdata_s = ctrl;
                2'd3:    rdata_s = status_s;
                default: err_s = 1'b1;
            endcase
        end
    end

    assign PREADY  = pready_s;
    assign PSLVERR = pready_s & err_s;
    assign PRDATA  = (done_s && !write_r) ? rdata_s : {DATA_W{1'b0}};

    // TX holding register; a new byte is only accepted while nothing is pending.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            tx_valid <= 1'b0;
            tx_data  <= {DATA_W{1'b0}};
        end else if (tx_valid && tx_ready) begin
            tx_valid <= 1'b0;
        end else if (done_s && write_r && (idx_s == 2'd0)) begin
            tx_valid <= 1'b1;
            tx_data  <= wdata_r;
        end
    end

    // RX buffer, full flag and sticky overrun (a new overrun beats a clear).
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            rxbuf_r      <= {DATA_W{1'b0}};
            rx_full_r    <= 1'b0;
            rx_overrun_r <= 1'b0;
        end else begin
            if (rx_valid) begin
                rxbuf_r   <= rx_data;
                rx_full_r <= 1'b1;
            end else if (rx_read_s) begin
                rx_full_r <= 1'b0;
            end
            rx_overrun_r <= new_ovr_s | (rx_overrun_r & ~ovr_clr_s);
        end
    end

    // Control register.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            ctrl <= {DATA_W{1'b0}};
        end else if (done_s && write_r && (idx_s == 2'd2)) begin
            ctrl <= wdata_r;
        end
    end

endmodule

// File: tb/tb_apb_spi_reg_bank.sv
// Scoreboard bench for apb_spi_reg_bank: a zero-wait instance and a two-wait instance
// share the bus signals but have separate PSEL lines.
module tb_apb_spi_reg_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic       psel0, psel2, penable, pwrite;
    logic [3:0] paddr;
    logic [7:0] pwdata;
    logic [7:0] prdata0, prdata2;
    logic       pready0, pready2, pslverr0, pslverr2;
    logic [7:0] txd0, txd2, ctrl0, ctrl2;
    logic       txv0, txv2;
    logic       tx_ready, rx_valid;
    logic [7:0] rx_data;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0] rdata;
        logic       err;
        int         lat;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    apb_spi_reg_bank #(.DATA_W(8), .ADDR_W(4), .WAIT_CYCLES(0)) dut0 (
        .PCLK(clk), .PRESET(rst), .PSEL(psel0), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata0), .PREADY(pready0),
        .PSLVERR(pslverr0), .tx_data(txd0), .tx_valid(txv0), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .ctrl(ctrl0));

    apb_spi_reg_bank #(.DATA_W(8), .ADDR_W(4), .WAIT_CYCLES(2)) dut2 (
        .PCLK(clk), .PRESET(rst), .PSEL(psel2), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata2), .PREADY(pready2),
        .PSLVERR(pslverr2), .tx_data(txd2), .tx_valid(txv2), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .ctrl(ctrl2));

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One APB transfer; optionally a received byte lands on the completing edge.
    task automatic apb_xfer(input string name, input int dut, input logic wr,
                            input logic [3:0] a, input logic [7:0] d,
                            input logic [7:0] exp_rd, input logic exp_err,
                            input logic do_rx, input logic [7:0] rx_b);
        exp_t e;
        exp_t got_e;
        int   cyc;
        bit   got;
        e.rdata = exp_rd;
        e.err   = exp_err;
        e.lat   = (dut == 0) ? 1 : 3;
        sb.push_back(e);
        @(posedge clk); #1;
        if (dut == 0) psel0 = 1'b1; else psel2 = 1'b1;
        penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (((dut == 0) ? pready0 : pready2) === 1'b1) got = 1'b1;
            else @(posedge clk);
        end
        got_e = sb.pop_front();
        check_val({name, ":latency"}, cyc, got_e.lat);
        check_val({name, ":prdata"}, (dut == 0) ? prdata0 : prdata2, got_e.rdata);
        check_val({name, ":pslverr"}, (dut == 0) ? pslverr0 : pslverr2, got_e.err);
        if (do_rx) begin
            rx_data  = rx_b;
            rx_valid = 1'b1;
        end
        @(posedge clk); #1;
        psel0 = 1'b0; psel2 = 1'b0; penable = 1'b0; rx_valid = 1'b0;
    endtask

    task automatic rx_pulse(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data = b; rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; psel0 = 1'b0; psel2 = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 4'd0; pwdata = 8'h00; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst:pready", pready2, 1'b0);
        check_val("rst:pslverr", pslverr2, 1'b0);
        check_val("rst:prdata", prdata2, 8'h00);
        check_val("rst:tx_valid", txv2, 1'b0);
        check_val("rst:tx_data", txd2, 8'h00);
        check_val("rst:ctrl", ctrl2, 8'h00);
        @(posedge clk); #1;
        rst = 1'b0;

        // zero-wait instance: CTRL write/read
        apb_xfer("w0_ctrl", 0, 1'b1, 4'd2, 8'hA5, 8'h00, 1'b0, 1'b0, 8'h00);
        check_val("w0:ctrl", ctrl0, 8'hA5);
        apb_xfer("r0_ctrl", 0, 1'b0, 4'd2, 8'h00, 8'hA5, 1'b0, 1'b0, 8'h00);

        // two-wait instance from here on
        apb_xfer("r_status0", 2, 1'b0, 4'd3, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
        apb_xfer("r_txdata", 2, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);

        apb_xfer("w_tx", 2, 1'b1, 4'd0, 8'h3C, 8'h00, 1'b0, 1'b0, 8'h00);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_val("tx:valid_held", txv2, 1'b1);
        check_val("tx:data_held", txd2, 8'h3C);
        apb_xfer("w_tx_busy", 2, 1'b1, 4'd0, 8'h55, 8'h00, 1'b1, 1'b0, 8'h00);
        check_val("tx:data_kept", txd2, 8'h3C);
        apb_xfer("r_status_tx", 2, 1'b0, 4'd3, 8'h00, 8'h01, 1'b0, 1'b0, 8'h00);
        @(posedge clk); #1; tx_ready = 1'b1;
        @(posedge clk); #1; tx_ready = 1'b0;
        check_val("tx:cleared", txv2, 1'b0);

        // two bytes without a read -> overrun
        rx_pulse(8'h11);
        rx_pulse(8'h22);
        apb_xfer("r_status_ovr", 2, 1'b0, 4'd3, 8'h00, 8'h06, 1'b0, 1'b0, 8'h00);
        apb_xfer("r_rx22", 2, 1'b0, 4'd1, 8'h00, 8'h22, 1'b0, 1'b0, 8'h00);
        apb_xfer("r_status_4", 2, 1'b0, 4'd3, 8'h00, 8'h04, 1'b0, 1'b0, 8'h00);
        apb_xfer("w_status_clr", 2, 1'b1, 4'd3, 8'h04, 8'h00, 1'b0, 1'b0, 8'h00);
        apb_xfer("r_status_clr", 2, 1'b0, 4'd3, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);

        // error cases leave state untouched
        apb_xfer("r_idx5", 2, 1'b0, 4'd5, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00);
        apb_xfer("r_idx4", 2, 1'b0, 4'd4, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00);
        apb_xfer("w_idx1", 2, 1'b1, 4'd1, 8'hEE, 8'h00, 1'b1, 1'b0, 8'h00);
        apb_xfer("r_status_err", 2, 1'b0, 4'd3, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
        apb_xfer("r_ctrl_err", 2, 1'b0, 4'd2, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);

        // byte arriving on the RXDATA read edge
        rx_pulse(8'h33);
        apb_xfer("r_rx_same", 2, 1'b0, 4'd1, 8'h00, 8'h33, 1'b0, 1'b1, 8'h44);
        apb_xfer("r_status_same", 2, 1'b0, 4'd3, 8'h00, 8'h02, 1'b0, 1'b0, 8'h00);
        apb_xfer("r_rx44", 2, 1'b0, 4'd1, 8'h00, 8'h44, 1'b0, 1'b0, 8'h00);

        // overrun coinciding with a clear keeps the flag
        rx_pulse(8'h55);
        apb_xfer("w_clr_vs_ovr", 2, 1'b1, 4'd3, 8'h04, 8'h00, 1'b0, 1'b1, 8'h66);
        apb_xfer("r_status_win", 2, 1'b0, 4'd3, 8'h00, 8'h06, 1'b0, 1'b0, 8'h00);
        apb_xfer("w_clr2", 2, 1'b1, 4'd3, 8'h04, 8'h00, 1'b0, 1'b0, 8'h00);
        apb_xfer("r_status_2", 2, 1'b0, 4'd3, 8'h00, 8'h02, 1'b0, 1'b0, 8'h00);
        apb_xfer("r_rx66", 2, 1'b0, 4'd1, 8'h00, 8'h66, 1'b0, 1'b0, 8'h00);

        // reset in the middle of a waiting access
        apb_xfer("w_ctrl5a", 2, 1'b1, 4'd2, 8'h5A, 8'h00, 1'b0, 1'b0, 8'h00);
        apb_xfer("w_tx99", 2, 1'b1, 4'd0, 8'h99, 8'h00, 1'b0, 1'b0, 8'h00);
        rx_pulse(8'h77);
        check_val("pre:ctrl", ctrl2, 8'h5A);
        @(posedge clk); #1;
        psel2 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'd2; pwdata = 8'h77;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        check_val("mid:waiting", pready2, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_val("mid:pready", pready2, 1'b0);
        check_val("mid:pslverr", pslverr2, 1'b0);
        check_val("mid:prdata", prdata2, 8'h00);
        check_val("mid:ctrl", ctrl2, 8'h00);
        check_val("mid:tx_valid", txv2, 1'b0);
        check_val("mid:tx_data", txd2, 8'h00);
        @(posedge clk); #1;
        rst = 1'b0; psel2 = 1'b0; penable = 1'b0;
        apb_xfer("post:status", 2, 1'b0, 4'd3, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
        apb_xfer("post:rx", 2, 1'b0, 4'd1, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
        apb_xfer("post:w_ctrl", 2, 1'b1, 4'd2, 8'h12, 8'h00, 1'b0, 1'b0, 8'h00);
        apb_xfer("post:r_ctrl", 2, 1'b0, 4'd2, 8'h00, 8'h12, 1'b0, 1'b0, 8'h00);
        check_val("post:ctrl", ctrl2, 8'h12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
